// File: rtl/if_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue_pkg
// Purpose  : Shared widths and reset PC for the instruction fetch queue.
// Revision : 1.0 - initial release
// ============================================================================
package if_fetch_queue_pkg;

    localparam int                 REG_BUS    = 64;
    localparam int                 INST_BUS   = 32;
    localparam logic [REG_BUS-1:0] PC_START   = 64'h8000_0000;
    localparam int                 INST_BYTES = INST_BUS / 8;

endpackage
`default_nettype wire

// File: rtl/if_fetch_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : Synchronous FIFO with flush; wrap bit on each pointer tells
//            full from empty, so non-power-of-two depths are supported.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    function automatic logic [IDX_W:0] ptr_inc(input logic [IDX_W:0] p);
        if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
            ptr_inc = {~p[IDX_W], {IDX_W{1'b0}}};
        end else begin
            ptr_inc = p + 1'b1;
        end
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_comb begin
        count = '0;
        if (wr_ptr_q[IDX_W] == rd_ptr_q[IDX_W]) begin
            count = CNT_W'(wr_ptr_q[IDX_W-1:0]) - CNT_W'(rd_ptr_q[IDX_W-1:0]);
        end else begin
            count = CNT_W'(DEPTH) - CNT_W'(rd_ptr_q[IDX_W-1:0])
                  + CNT_W'(wr_ptr_q[IDX_W-1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q[IDX_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Purpose  : Multi-outstanding instruction fetch with an in-order decode
//            queue, credit-based issue and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int                ADDR_W          = REG_BUS,
    parameter int                DATA_W          = REG_BUS,
    parameter int                INST_W          = INST_BYTES * 8,
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] PC_START        = if_fetch_queue_pkg::PC_START[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_req_valid,
    output logic              if_req_op,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [DATA_W-1:0] inst_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              stall_req
);

    localparam int WORDS  = DATA_W / INST_W;
    localparam int STEP   = INST_W / 8;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int QCNT_W = $clog2(DEPTH + 1);
    localparam int QW     = ADDR_W + INST_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              started_q,  started_d;

    logic [OUT_W-1:0]  outstanding;
    logic [QCNT_W-1:0] queue_count;
    logic [ADDR_W-1:0] resp_pc;
    logic [INST_W-1:0] resp_inst;
    logic [QW-1:0]     q_head;
    logic              credit_ok;
    logic              addr_hs;
    logic              keep_resp;
    logic              q_pop;

    // Reserving a queue slot per in-flight request means responses never stall.
    assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING)
                    && ((int'(outstanding) + int'(queue_count)) < DEPTH);

    assign if_req_valid = started_q & ~redirect_valid & credit_ok;
    assign if_req_op    = 1'b0;
    assign inst_addr    = fetch_pc_q;
    assign addr_hs      = if_req_valid & inst_addr_ok;

    assign keep_resp  = inst_data_ok & (drop_cnt_q == '0) & ~redirect_valid;
    assign inst_valid = (queue_count != '0);
    assign q_pop      = inst_valid & inst_ready & ~redirect_valid;
    assign inst       = inst_valid ? q_head[INST_W-1:0]  : '0;
    assign inst_pc    = inst_valid ? q_head[QW-1:INST_W] : '0;
    assign stall_req  = ~inst_valid & ~redirect_valid;

    generate
        if (WORDS > 1) begin : g_word_sel
            localparam int SEL_LO = $clog2(STEP);
            localparam int SEL_W  = $clog2(WORDS);
            logic [SEL_W-1:0] word_idx;
            assign word_idx  = resp_pc[SEL_LO +: SEL_W];
            assign resp_inst = inst_data[word_idx*INST_W +: INST_W];
        end else begin : g_word_one
            assign resp_inst = inst_data[INST_W-1:0];
        end
    endgenerate

    always_comb begin
        started_d  = 1'b1;
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            // Outstanding already includes responses pending a drop, so
            // every response still owed after this cycle becomes stale.
            drop_cnt_d = outstanding - OUT_W'(inst_data_ok);
        end else begin
            if (addr_hs) fetch_pc_d = fetch_pc_q + ADDR_W'(STEP);
            if (inst_data_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q  <= 1'b0;
            fetch_pc_q <= PC_START;
            drop_cnt_q <= '0;
        end else begin
            started_q  <= started_d;
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (addr_hs),
        .push_data (fetch_pc_q),
        .pop       (inst_data_ok),
        .pop_data  (resp_pc),
        .count     (outstanding)
    );

    fetch_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep_resp),
        .push_data ({resp_pc, resp_inst}),
        .pop       (q_pop),
        .pop_data  (q_head),
        .count     (queue_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Purpose  : Self-checking bench: in-order bus model plus decode scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int          ADDR_W   = 64;
    localparam int          DATA_W   = 64;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [63:0] PC_START = 64'h8000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              if_req_valid;
    logic              if_req_op;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok = 1'b0;
    logic              inst_data_ok = 1'b0;
    logic [DATA_W-1:0] inst_data = '0;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready = 1'b0;
    logic              stall_req;

    if_fetch_queue #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .INST_W          (INST_W),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .PC_START        (PC_START)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_req_valid   (if_req_valid),
        .if_req_op      (if_req_op),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_data      (inst_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .stall_req      (stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          issue;
        bit          stale;
    } bus_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    bus_t        bus_q[$];
    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc;
    int          hs_cnt;
    int          drops_seen;
    int          valid_cnt;
    int          first_valid_cyc;
    bit          got_first;
    bit          got_hs;
    logic [63:0] exp_pc;
    logic [63:0] first_pc_seen;
    logic [63:0] first_hs_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [63:0] bus_word(input logic [63:0] a);
        logic [63:0] b;
        b = {a[63:3], 3'b000};
        return {inst_of(b + 64'd4), inst_of(b)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_data      = '0;
        inst_ready     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_req_valid",  64'(if_req_valid), 64'd0);
        check_eq("rst_inst_valid", 64'(inst_valid),   64'd0);
        check_eq("rst_inst",       64'(inst),         64'd0);
        check_eq("rst_inst_pc",    inst_pc,           64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_req_valid", 64'(if_req_valid), 64'd0);
        bus_q.delete();
        sb_q.delete();
        cyc             = 0;
        hs_cnt          = 0;
        drops_seen      = 0;
        valid_cnt       = 0;
        first_valid_cyc = -1;
        got_first       = 1'b0;
        got_hs          = 1'b0;
        exp_pc          = PC_START;
        first_pc_seen   = '0;
        first_hs_addr   = '0;
    endtask

    task automatic step(input bit redir, input logic [63:0] rpc, input bit aok,
                        input bit dok_en, input bit rdy);
        bit   dok;
        exp_t e;
        bus_t b;
        @(negedge clk);
        cyc++;
        dok = dok_en && (bus_q.size() > 0) && (bus_q[0].issue < cyc);
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_addr_ok   = aok;
        inst_ready     = rdy;
        inst_data_ok   = dok;
        inst_data      = dok ? bus_word(bus_q[0].addr) : 64'd0;
        #1;
        check_eq("inst_valid", 64'(inst_valid), 64'(sb_q.size() > 0));
        check_eq("stall_req",  64'(stall_req),  64'((sb_q.size() == 0) && !redir));
        check_eq("if_req_op",  64'(if_req_op),  64'd0);
        check_eq("outstanding_cap", 64'(bus_q.size() <= MAX_OUT), 64'd1);
        if (redir) check_eq("req_on_redirect", 64'(if_req_valid), 64'd0);
        if (inst_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (inst_valid && sb_q.size() > 0) begin
            check_eq("inst_pc", inst_pc,      sb_q[0].pc);
            check_eq("inst",    64'(inst),    64'(sb_q[0].inst));
            if (rdy && !redir) begin
                if (!got_first) begin
                    got_first     = 1'b1;
                    first_pc_seen = inst_pc;
                end
                void'(sb_q.pop_front());
            end
        end
        if (dok) begin
            b = bus_q.pop_front();
            if (b.stale) begin
                drops_seen++;
            end else if (!redir) begin
                e.pc   = b.addr;
                e.inst = inst_of(b.addr);
                sb_q.push_back(e);
            end
        end
        if (redir) begin
            sb_q.delete();
            foreach (bus_q[i]) bus_q[i].stale = 1'b1;
        end
        if (if_req_valid) check_eq("inst_addr", inst_addr, exp_pc);
        if (if_req_valid && aok) begin
            if (!got_hs) begin
                got_hs        = 1'b1;
                first_hs_addr = inst_addr;
            end
            b.addr  = exp_pc;
            b.issue = cyc;
            b.stale = 1'b0;
            bus_q.push_back(b);
            hs_cnt++;
            exp_pc = exp_pc + 64'd4;
        end
        if (redir) exp_pc = rpc;
    endtask

    initial begin
        // Streaming: first instruction at cycle 3, then one every cycle.
        do_reset();
        repeat (12) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check_eq("t1_first_valid_cyc", 64'(first_valid_cyc), 64'd3);
        check_eq("t1_no_bubbles",      64'(valid_cnt),       64'd10);
        check_eq("t1_first_pc",        first_pc_seen,        64'h8000_0000);

        // Back-pressure: credit stops issue after four requests.
        do_reset();
        repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_eq("t2_hs_count",  64'(hs_cnt),       64'd4);
        check_eq("t2_req_valid", 64'(if_req_valid), 64'd0);
        check_eq("t2_head_pc",   inst_pc,           64'h8000_0000);
        got_hs = 1'b0;
        repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check_eq("t2_resume_addr", first_hs_addr, 64'h8000_0010);

        // Redirect with two requests in flight.
        do_reset();
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 64'h8000_1000, 1'b1, 1'b0, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check_eq("t3_drops",    64'(drops_seen), 64'd2);
        check_eq("t3_first_pc", first_pc_seen,   64'h8000_1000);

        // Redirect coincident with a response.
        do_reset();
        repeat (2) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 64'h8000_2000, 1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        check_eq("t4_drops",    64'(drops_seen), 64'd1);
        check_eq("t4_first_pc", first_pc_seen,   64'h8000_2000);

        // Slow bus: request held stable while addr_ok is low.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
            check_eq("t5_req_valid", 64'(if_req_valid), 64'd1);
            check_eq("t5_addr",      inst_addr,         PC_START);
            check_eq("t5_stall",     64'(stall_req),    64'd1);
        end
        repeat (6) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-stream with two in flight.
        do_reset();
        repeat (3) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_async_req_valid", 64'(if_req_valid), 64'd0);
        check_eq("t6_async_inst_valid", 64'(inst_valid),  64'd0);
        check_eq("t6_async_inst",      64'(inst),         64'd0);
        check_eq("t6_async_inst_pc",   inst_pc,           64'd0);
        do_reset();
        repeat (5) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_eq("t6_hs_count",  64'(hs_cnt),  64'd2);
        check_eq("t6_first_hs",  first_hs_addr, PC_START);
        repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
